// File: rtl/irq_priority_encoder16_pkg.sv
// ----------------------------------------------------------------------------
// irq_priority_encoder16_pkg
// Shared definitions for the 16-line interrupt priority encoder:
//   - NUM_LINES / CODE_W  : request line count and code width
//   - irq_state_e         : presentation handshake states
//   - code_to_onehot()    : expands a 4-bit code into a 16-bit one-hot vector
// ----------------------------------------------------------------------------
package irq_priority_encoder16_pkg;

  localparam int NUM_LINES = 16;
  localparam int CODE_W    = 4;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_PRESENT  = 2'd1,
    ST_WAIT_REL = 2'd2
  } irq_state_e;

  function automatic logic [NUM_LINES-1:0] code_to_onehot(input logic [CODE_W-1:0] code);
    logic [NUM_LINES-1:0] onehot;
    onehot = 16'h0001 << code;
    return onehot;
  endfunction

endpackage

// File: rtl/irq_priority_encoder16_prienc.sv
// ----------------------------------------------------------------------------
// priority_encoder16
// Combinational 16->4 highest-set-bit encoder with an any-set flag; the same
// function as a cascaded pair of 74148s, but with active-high polarity.
// Ports:
//   req   in  16  active-high request vector, bit 15 = highest priority
//   code  out  4  index of the highest set bit (0 when none set)
//   any   out  1  at least one bit of req is set
// ----------------------------------------------------------------------------
module priority_encoder16
  import irq_priority_encoder16_pkg::*;
(
  input  logic [NUM_LINES-1:0] req,
  output logic [CODE_W-1:0]    code,
  output logic                 any
);

  // Ascending scan: a later (higher) set bit overwrites any lower one.
  always_comb begin
    code = 4'd0;
    for (int i = 0; i < NUM_LINES; i++) begin
      code = req[i] ? CODE_W'(i) : code;
    end
  end

  assign any = |req;

endmodule

// File: rtl/irq_priority_encoder16.sv
// ----------------------------------------------------------------------------
// irq_priority_encoder16
// Latches falling edges on 16 active-low asynchronous request lines and
// presents the highest-priority pending index through an acknowledge
// handshake. A presented request stays frozen (no preemption) until _ACK.
// Optional feature macro: IRQ_ENCODER_MASK_EN (adds MASK_WE / MASK_D and a
// mask register; otherwise every line is enabled).
// Ports:
//   clk      in   1  system clock, rising edge
//   _MR      in   1  master reset, asynchronous, active-low
//   _REQ     in  16  request lines, active-low, asynchronous to clk
//   _ACK     in   1  acknowledge, active-low, sampled on clk
//   VALID    out  1  CODE holds a presented request
//   CODE     out  4  index of the presented request
//   _GS      out  1  group select, active-low, always == !VALID
//   MASK_WE  in   1  (mask build) load MASK_D into the mask
//   MASK_D   in  16  (mask build) 1 = line enabled
// ----------------------------------------------------------------------------
module irq_priority_encoder16
  import irq_priority_encoder16_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 _MR,
  input  logic [NUM_LINES-1:0] _REQ,
  input  logic                 _ACK,
  output logic                 VALID,
  output logic [CODE_W-1:0]    CODE,
  output logic                 _GS
`ifdef IRQ_ENCODER_MASK_EN
  ,
  input  logic                 MASK_WE,
  input  logic [NUM_LINES-1:0] MASK_D
`endif
);

  logic [SYNC_STAGES-1:0][NUM_LINES-1:0] sync_r;
  logic [SYNC_STAGES-1:0]                sync_vld_r;
  logic [NUM_LINES-1:0]                  synced_s;
  logic [NUM_LINES-1:0]                  armed_r;
  logic [NUM_LINES-1:0]                  fall_s;
  logic [NUM_LINES-1:0]                  clr_s;
  logic [NUM_LINES-1:0]                  pending_r;
  logic [NUM_LINES-1:0]                  mask_s;
  logic [CODE_W-1:0]                     sel_code_s;
  logic                                  sel_any_s;
  irq_state_e                            state_r;
  logic                                  valid_r;
  logic [CODE_W-1:0]                     code_r;
  logic                                  gs_r;

  // Synchroniser chain for the request lines plus a token marking real samples.
  always_ff @(posedge clk or negedge _MR) begin
    if (!_MR) begin
      sync_r     <= {SYNC_STAGES{16'hffff}};
      sync_vld_r <= '0;
    end else begin
      sync_r     <= {sync_r[SYNC_STAGES-2:0], _REQ};
      sync_vld_r <= {sync_vld_r[SYNC_STAGES-2:0], 1'b1};
    end
  end

  assign synced_s = sync_r[SYNC_STAGES-1];

  // A line arms only after a genuine high sample; the reset fill of the
  // chain does not count, so lines held low through reset stay quiet.
  always_ff @(posedge clk or negedge _MR) begin
    if (!_MR) begin
      armed_r <= 16'h0000;
    end else begin
      armed_r <= sync_vld_r[SYNC_STAGES-1] ? synced_s : 16'h0000;
    end
  end

  assign fall_s = armed_r & ~synced_s;

  // Clear request for the presented index when the handshake accepts it.
  always_comb begin
    clr_s = 16'h0000;
    if ((state_r == ST_PRESENT) && !_ACK) begin
      clr_s = code_to_onehot(code_r);
    end else begin
      clr_s = 16'h0000;
    end
  end

  // Pending request register; a fresh edge beats a same-cycle clear.
  always_ff @(posedge clk or negedge _MR) begin
    if (!_MR) begin
      pending_r <= 16'h0000;
    end else begin
      pending_r <= (pending_r & ~clr_s) | fall_s;
    end
  end

`ifdef IRQ_ENCODER_MASK_EN
  logic [NUM_LINES-1:0] mask_r;

  // Line enable mask, loaded by the control logic.
  always_ff @(posedge clk or negedge _MR) begin
    if (!_MR) begin
      mask_r <= 16'hffff;
    end else if (MASK_WE) begin
      mask_r <= MASK_D;
    end else begin
      mask_r <= mask_r;
    end
  end

  assign mask_s = mask_r;
`else
  assign mask_s = 16'hffff;
`endif

  priority_encoder16 u_prienc (
    .req  (pending_r & mask_s),
    .code (sel_code_s),
    .any  (sel_any_s)
  );

  // Presentation handshake with registered VALID / CODE / _GS.
  always_ff @(posedge clk or negedge _MR) begin
    if (!_MR) begin
      state_r <= ST_IDLE;
      valid_r <= 1'b0;
      code_r  <= 4'd0;
      gs_r    <= 1'b1;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (sel_any_s) begin
            code_r  <= sel_code_s;
            valid_r <= 1'b1;
            gs_r    <= 1'b0;
            state_r <= ST_PRESENT;
          end
        end
        ST_PRESENT: begin
          if (!_ACK) begin
            valid_r <= 1'b0;
            gs_r    <= 1'b1;
            state_r <= ST_WAIT_REL;
          end
        end
        ST_WAIT_REL: begin
          if (_ACK) begin
            state_r <= ST_IDLE;
          end
        end
        default: begin
          valid_r <= 1'b0;
          gs_r    <= 1'b1;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign VALID = valid_r;
  assign CODE  = code_r;
  assign _GS   = gs_r;

endmodule

// File: tb/tb_irq_priority_encoder16.sv
// ----------------------------------------------------------------------------
// tb_irq_priority_encoder16
// Self-checking bench: directed scenarios plus a randomized run, all compared
// against a cycle-level behavioural model of the request/handshake rules.
// Mask scenario is built only with IRQ_ENCODER_MASK_EN defined.
// ----------------------------------------------------------------------------
module tb_irq_priority_encoder16;

  localparam int SYNC = 2;

  logic        clk = 1'b0;
  logic        mr;
  logic [15:0] req;
  logic        ack;
  logic        valid;
  logic [3:0]  code;
  logic        gs;
  logic        mask_we;
  logic [15:0] mask_d;

  int n_checks = 0;
  int n_errors = 0;

  irq_priority_encoder16 #(.SYNC_STAGES(SYNC)) dut (
    .clk   (clk),
    ._MR   (mr),
    ._REQ  (req),
    ._ACK  (ack),
    .VALID (valid),
    .CODE  (code),
    ._GS   (gs)
`ifdef IRQ_ENCODER_MASK_EN
    ,
    .MASK_WE (mask_we),
    .MASK_D  (mask_d)
`endif
  );

  always #5 clk = ~clk;

  // ---------------- behavioural reference model ----------------
  // Raw samples taken at each edge; a 1->0 between consecutive post-reset
  // samples becomes pending SYNC edges after the sample that saw the low.
  logic [15:0] m_pending, m_mask, m_prev;
  logic [15:0] m_sched [8];
  int          m_nsamp, m_edge, m_phase; // phase: 0 idle, 1 presenting, 2 waiting release
  logic        m_valid;
  logic [3:0]  m_code;

  function automatic int highest(input logic [15:0] v);
    for (int i = 15; i >= 0; i--) if (v[i]) return i;
    return -1;
  endfunction

  task automatic model_reset();
    m_pending = 16'h0000; m_mask = 16'hffff; m_prev = 16'hffff;
    m_nsamp = 0; m_edge = 0; m_phase = 0; m_valid = 1'b0; m_code = 4'd0;
    for (int i = 0; i < 8; i++) m_sched[i] = 16'h0000;
  endtask

  task automatic model_edge(input logic [15:0] r, input logic a, input logic we, input logic [15:0] md);
    logic [15:0] set_v, clr_v, fall_v;
    int h;
    set_v = m_sched[m_edge % 8];
    m_sched[m_edge % 8] = 16'h0000;
    fall_v = (m_nsamp > 0) ? (m_prev & ~r) : 16'h0000;
    m_sched[(m_edge + SYNC) % 8] |= fall_v;
    m_prev = r;
    m_nsamp++;
    clr_v = 16'h0000;
    if (m_phase == 0) begin
      h = highest(m_pending & m_mask);
      if (h >= 0) begin m_code = 4'(h); m_valid = 1'b1; m_phase = 1; end
    end else if (m_phase == 1) begin
      if (!a) begin clr_v[m_code] = 1'b1; m_valid = 1'b0; m_phase = 2; end
    end else begin
      if (a) m_phase = 0;
    end
    m_pending = (m_pending & ~clr_v) | set_v;
    if (we) m_mask = md;
    m_edge++;
  endtask

  // Drive one clock: inputs set at the falling edge, model stepped with the
  // values present at the rising edge, outputs sampled at the next falling edge.
  task automatic step(input logic [15:0] r, input logic a);
    req = r; ack = a;
    @(posedge clk);
    model_edge(r, a, mask_we, mask_d);
    @(negedge clk);
  endtask

  task automatic apply_reset(input logic [15:0] r);
    mr = 1'b0; req = r; ack = 1'b1; mask_we = 1'b0; mask_d = 16'hffff;
    model_reset();
    repeat (2) @(negedge clk);
    mr = 1'b1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    mr = 1'b1; req = 16'hffff; ack = 1'b1; mask_we = 1'b0; mask_d = 16'hffff;
    @(negedge clk);
    mr = 1'b0; req = 16'h0000;
    #1;
    n_checks++;
    if ({valid, code, gs} !== 6'b0_0000_1) begin
      n_errors++; $display("FAIL reset_async got v=%b c=%0d gs=%b want v=0 c=0 gs=1", valid, code, gs);
    end
    model_reset();
    @(negedge clk);
    mr = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step(16'h0000, 1'b1);
      n_checks++;
      if (valid !== 1'b0 || gs !== 1'b1 || code !== 4'd0) begin
        n_errors++; $display("FAIL reset_held_low cyc=%0d got v=%b c=%0d gs=%b want v=0 c=0 gs=1", i, valid, code, gs);
      end
    end
  endtask

  task automatic test_single_pulse();
    int lat;
    apply_reset(16'hffff);
    lat = 0;
    for (int i = 0; i < 3; i++) step(16'hffff, 1'b1);
    for (int i = 1; i <= 8; i++) begin
      step((i == 1) ? 16'hffdf : 16'hffff, 1'b1);
      n_checks++;
      if ({valid, code, gs} !== {m_valid, m_code, ~m_valid}) begin
        n_errors++; $display("FAIL single_model cyc=%0d got v=%b c=%0d gs=%b want v=%b c=%0d", i, valid, code, gs, m_valid, m_code);
      end
      if (valid === 1'b1 && lat == 0) lat = i;
    end
    n_checks++;
    if (lat != SYNC + 2 || code !== 4'd5) begin
      n_errors++; $display("FAIL single_latency got lat=%0d code=%0d want lat=%0d code=5", lat, code, SYNC + 2);
    end
    step(16'hffff, 1'b0);
    n_checks++;
    if (valid !== 1'b0 || gs !== 1'b1) begin
      n_errors++; $display("FAIL single_ack got v=%b gs=%b want v=0 gs=1", valid, gs);
    end
    for (int i = 0; i < 6; i++) step(16'hffff, 1'b1);
    n_checks++;
    if (valid !== 1'b0 || code !== 4'd5) begin
      n_errors++; $display("FAIL single_cleared got v=%b c=%0d want v=0 c=5", valid, code);
    end
  endtask

  task automatic test_simultaneous();
    logic [3:0] seen [$];
    logic       prev_v, a;
    apply_reset(16'hffff);
    for (int i = 0; i < 3; i++) step(16'hffff, 1'b1);
    prev_v = 1'b0; a = 1'b1;
    for (int i = 0; i < 30; i++) begin
      step((i == 0) ? 16'hffff : 16'h7df7, a);
      n_checks++;
      if ({valid, code, gs} !== {m_valid, m_code, ~m_valid} || gs !== ~valid) begin
        n_errors++; $display("FAIL simul_model cyc=%0d got v=%b c=%0d gs=%b want v=%b c=%0d", i, valid, code, gs, m_valid, m_code);
      end
      if (valid === 1'b1 && prev_v === 1'b0) seen.push_back(code);
      prev_v = valid;
      a = ~m_valid;
    end
    n_checks++;
    if (seen.size() != 3 || seen[0] !== 4'd15 || seen[1] !== 4'd9 || seen[2] !== 4'd3) begin
      n_errors++; $display("FAIL simul_order got n=%0d %p want 15,9,3", seen.size(), seen);
    end
  endtask

  task automatic test_no_preempt();
    apply_reset(16'hffff);
    for (int i = 0; i < 3; i++) step(16'hffff, 1'b1);
    for (int i = 0; i < 8; i++) step(16'hfffb, 1'b1);
    for (int i = 0; i < 6; i++) begin
      step(16'hbffb, 1'b1);
      n_checks++;
      if (valid !== 1'b1 || code !== 4'd2) begin
        n_errors++; $display("FAIL no_preempt cyc=%0d got v=%b c=%0d want v=1 c=2", i, valid, code);
      end
    end
    step(16'hbffb, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step(16'hbffb, 1'b1);
      n_checks++;
      if ({valid, code, gs} !== {m_valid, m_code, ~m_valid}) begin
        n_errors++; $display("FAIL no_preempt_model cyc=%0d got v=%b c=%0d want v=%b c=%0d", i, valid, code, m_valid, m_code);
      end
    end
    n_checks++;
    if (valid !== 1'b1 || code !== 4'd14) begin
      n_errors++; $display("FAIL no_preempt_next got v=%b c=%0d want v=1 c=14", valid, code);
    end
  endtask

  task automatic test_long_ack();
    apply_reset(16'hffff);
    for (int i = 0; i < 3; i++) step(16'hffff, 1'b1);
    for (int i = 0; i < 6; i++) step(16'hff3f, 1'b1);
    n_checks++;
    if (valid !== 1'b1 || code !== 4'd7) begin
      n_errors++; $display("FAIL long_ack_first got v=%b c=%0d want v=1 c=7", valid, code);
    end
    for (int i = 0; i < 5; i++) begin
      step(16'hff3f, 1'b0);
      n_checks++;
      if (valid !== 1'b0 || gs !== 1'b1) begin
        n_errors++; $display("FAIL long_ack_hold cyc=%0d got v=%b gs=%b want v=0 gs=1", i, valid, gs);
      end
    end
    for (int i = 0; i < 3; i++) step(16'hff3f, 1'b1);
    n_checks++;
    if (valid !== 1'b1 || code !== 4'd6 || m_pending !== 16'h0040) begin
      n_errors++; $display("FAIL long_ack_second got v=%b c=%0d want v=1 c=6", valid, code);
    end
  endtask

  task automatic test_reset_mid();
    apply_reset(16'hffff);
    for (int i = 0; i < 3; i++) step(16'hffff, 1'b1);
    for (int i = 0; i < 6; i++) step(16'hfeff, 1'b1);
    @(negedge clk);
    #2 mr = 1'b0;
    #1;
    n_checks++;
    if ({valid, code, gs} !== 6'b0_0000_1) begin
      n_errors++; $display("FAIL reset_mid got v=%b c=%0d gs=%b want v=0 c=0 gs=1", valid, code, gs);
    end
    model_reset();
    @(negedge clk);
    mr = 1'b1;
    for (int i = 0; i < 8; i++) step(16'hfeff, 1'b1);
    n_checks++;
    if (valid !== 1'b0) begin
      n_errors++; $display("FAIL reset_mid_lost got v=%b want v=0", valid);
    end
  endtask

`ifdef IRQ_ENCODER_MASK_EN
  task automatic test_mask();
    apply_reset(16'hffff);
    mask_we = 1'b1; mask_d = 16'hfffe;
    step(16'hffff, 1'b1);
    mask_we = 1'b0;
    for (int i = 0; i < 8; i++) step((i == 1) ? 16'hfffe : 16'hffff, 1'b1);
    n_checks++;
    if (valid !== 1'b0) begin
      n_errors++; $display("FAIL mask_blocked got v=%b want v=0", valid);
    end
    mask_we = 1'b1; mask_d = 16'hffff;
    step(16'hffff, 1'b1);
    mask_we = 1'b0;
    n_checks++;
    if (valid !== 1'b0) begin
      n_errors++; $display("FAIL mask_write_cycle got v=%b want v=0", valid);
    end
    step(16'hffff, 1'b1);
    n_checks++;
    if (valid !== 1'b1 || code !== 4'd0) begin
      n_errors++; $display("FAIL mask_release got v=%b c=%0d want v=1 c=0", valid, code);
    end
  endtask
`endif

  task automatic test_random();
    logic [15:0] r;
    logic        a;
    apply_reset(16'hffff);
    r = 16'hffff;
    for (int i = 0; i < 600; i++) begin
      r = r ^ 16'($urandom() & $urandom() & $urandom());
      a = ($urandom_range(0, 2) != 0);
`ifdef IRQ_ENCODER_MASK_EN
      mask_we = ($urandom_range(0, 15) == 0);
      mask_d  = 16'($urandom() | $urandom());
`endif
      step(r, a);
      n_checks++;
      if ({valid, code, gs} !== {m_valid, m_code, ~m_valid}) begin
        n_errors++; $display("FAIL random cyc=%0d got v=%b c=%0d gs=%b want v=%b c=%0d gs=%b", i, valid, code, gs, m_valid, m_code, ~m_valid);
      end
    end
    mask_we = 1'b0;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single_pulse();
    test_simultaneous();
    test_no_preempt();
    test_long_ack();
    test_reset_mid();
`ifdef IRQ_ENCODER_MASK_EN
    test_mask();
`endif
    test_random();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
